// File: rtl/mem_copier_if.sv
// Memory-side bus of the copier: one shared address, a write strobe,
// write data out and combinational read data back.
interface mem_copier_if #(
    parameter int W = 8,
    parameter int A = 8
);
    logic [A-1:0] MemAddress;
    logic         MemWriteEn;
    logic [W-1:0] MemWrData;
    logic [W-1:0] MemRdData;

    modport master (
        output MemAddress,
        output MemWriteEn,
        output MemWrData,
        input  MemRdData
    );

    modport slave (
        input  MemAddress,
        input  MemWriteEn,
        input  MemWrData,
        output MemRdData
    );
endinterface

// File: rtl/mem_copier.sv
// Byte-at-a-time memory copier. One read cycle then one write cycle per
// byte, ascending addresses, so overlapping regions replicate forward.
// The memory bus outputs are registered: each state's address/strobe is
// loaded on the edge that enters that state.
module mem_copier #(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [A-1:0] SrcAddr,
    input  logic [A-1:0] DstAddr,
    input  logic [A:0]   Length,
    output logic         Busy,
    output logic         Done,
    mem_copier_if.master Mem
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t       state;
    logic [A-1:0] src;
    logic [A-1:0] dst;
    logic [A:0]   len;
    logic [A:0]   cnt;
    logic [A:0]   cntInc;
    logic [W-1:0] hold;
    logic [A-1:0] addr;
    logic         wrEn;
    logic [A-1:0] readAddrNext;
    logic [A-1:0] writeAddr;

    // Next byte index and the wrapped addresses the FSM loads into the bus.
    always_comb begin
        cntInc       = cnt + {{A{1'b0}}, 1'b1};
        readAddrNext = src + cntInc[A-1:0];
        writeAddr    = dst + cnt[A-1:0];
    end

    assign Mem.MemAddress = addr;
    assign Mem.MemWriteEn = wrEn;
    assign Mem.MemWrData  = wrEn ? hold : '0;

    // Copy sequencer; the bus and status outputs are registered alongside the state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            src   <= '0;
            dst   <= '0;
            len   <= '0;
            cnt   <= '0;
            hold  <= '0;
            addr  <= '0;
            wrEn  <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        src <= SrcAddr;
                        dst <= DstAddr;
                        len <= Length;
                        cnt <= '0;
                        if (Length != '0) begin
                            state <= READ;
                            Busy  <= 1'b1;
                            addr  <= SrcAddr;
                        end else begin
                            state <= DONE;
                            Done  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    hold  <= Mem.MemRdData;
                    state <= WRITE;
                    addr  <= writeAddr;
                    wrEn  <= 1'b1;
                end
                WRITE: begin
                    cnt  <= cntInc;
                    wrEn <= 1'b0;
                    if (cntInc == len) begin
                        state <= DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        addr  <= '0;
                    end else begin
                        state <= READ;
                        addr  <= readAddrNext;
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    addr  <= '0;
                    wrEn  <= 1'b0;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copier.sv
// Scoreboard bench for mem_copier: a reference memory image predicts the
// read addresses, writes and Done timing; a negedge monitor checks them.
module tb_mem_copier;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic [7:0] SrcAddr;
    logic [7:0] DstAddr;
    logic [8:0] Length;
    logic       Busy;
    logic       Done;

    mem_copier_if #(.W(8), .A(8)) memIf ();

    mem_copier #(.W(8), .A(8)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .SrcAddr (SrcAddr),
        .DstAddr (DstAddr),
        .Length  (Length),
        .Busy    (Busy),
        .Done    (Done),
        .Mem     (memIf)
    );

    typedef struct {
        int cyc;
        int busy;
    } done_t;

    logic [7:0] mem    [256];
    logic [7:0] refMem [256];
    logic       tbWe = 1'b0;
    logic [7:0] tbAddr = 8'h00;
    logic [7:0] tbData = 8'h00;

    int    cycle = 0;
    int    errors = 0;
    int    checks = 0;
    int    busyCount = 0;
    int    doneCount = 0;
    bit    monitorOn = 1'b0;
    int    readQ [$];
    int    writeQ [$];
    done_t doneQ [$];

    // Free-running clock and cycle index.
    always #5 Clk = ~Clk;

    always @(posedge Clk) cycle <= cycle + 1;

    // Behavioural data memory: combinational read, DUT write has priority over bench pokes.
    assign memIf.MemRdData = mem[memIf.MemAddress];

    always @(posedge Clk) begin
        if (memIf.MemWriteEn) mem[memIf.MemAddress] <= memIf.MemWrData;
        else if (tbWe) mem[tbAddr] <= tbData;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic reportFail(input string name, input logic [31:0] actual);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got 0x%0h, expected nothing (cycle %0d)", name, actual, cycle);
    endtask

    // Monitor: pops expected reads, writes and Done pulses as the DUT presents them.
    always @(negedge Clk) begin
        if (monitorOn) begin
            if (Reset) begin
                busyCount = 0;
            end else begin
                if (Busy) busyCount++;
                if (!Busy) begin
                    checkOutput("idleBus", 32'({memIf.MemAddress, memIf.MemWriteEn, memIf.MemWrData}), 32'h0);
                end else if (memIf.MemWriteEn) begin
                    if (writeQ.size() == 0) reportFail("unexpectedWrite", 32'({memIf.MemAddress, memIf.MemWrData}));
                    else checkOutput("writeAddrData", 32'({memIf.MemAddress, memIf.MemWrData}), writeQ.pop_front());
                end else begin
                    if (readQ.size() == 0) reportFail("unexpectedRead", 32'(memIf.MemAddress));
                    else checkOutput("readAddr", 32'(memIf.MemAddress), readQ.pop_front());
                end
                if (Done) begin
                    if (doneQ.size() == 0) begin
                        reportFail("unexpectedDone", cycle);
                    end else begin
                        done_t d;
                        d = doneQ.pop_front();
                        checkOutput("doneCycle", cycle, d.cyc);
                        checkOutput("busyCycles", busyCount, d.busy);
                    end
                    busyCount = 0;
                    doneCount++;
                end
            end
        end
    end

    task automatic pokeMem(input int a, input int d);
        @(negedge Clk);
        tbWe   = 1'b1;
        tbAddr = 8'(a);
        tbData = 8'(d);
        refMem[a & 255] = 8'(d);
        @(negedge Clk);
        tbWe = 1'b0;
    endtask

    // Reference copy of n bytes: ascending, each byte read then written.
    task automatic modelCopy(input int src, input int dst, input int n, input int nReads);
        for (int i = 0; i < n; i++) begin
            refMem[(dst + i) & 255] = refMem[(src + i) & 255];
            writeQ.push_back((((dst + i) & 255) << 8) | int'(refMem[(dst + i) & 255]));
        end
        for (int i = 0; i < nReads; i++) readQ.push_back((src + i) & 255);
    endtask

    // One complete copy; optionally pulses Start again glitchAt cycles after the start edge.
    task automatic applyStimulus(input int src, input int dst, input int len, input int glitchAt);
        int t;
        int doneOff;
        int startDone;
        bit seen;
        modelCopy(src, dst, len, len);
        doneOff = (len == 0) ? 1 : 2 * len + 1;
        @(negedge Clk);
        Start   = 1'b1;
        SrcAddr = 8'(src);
        DstAddr = 8'(dst);
        Length  = 9'(len);
        t = cycle;
        startDone = doneCount;
        doneQ.push_back('{t + doneOff, 2 * len});
        for (int k = 1; k <= doneOff; k++) begin
            @(negedge Clk);
            Start = 1'b0;
            if (k == glitchAt) begin
                Start   = 1'b1;
                SrcAddr = 8'($urandom);
                DstAddr = 8'($urandom);
                Length  = 9'($urandom_range(1, 256));
            end
        end
        @(negedge Clk);
        Start = 1'b0;
        seen = (doneCount != startDone);
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge Clk);
            seen = (doneCount != startDone);
        end
        if (!seen) begin
            reportFail("doneTimeout", cycle);
            readQ.delete();
            writeQ.delete();
            doneQ.delete();
        end
        checkOutput("queuesDrained", readQ.size() + writeQ.size() + doneQ.size(), 0);
    endtask

    initial begin
        int t;
        int startDone;
        int diffs;

        Reset   = 1'b1;
        Start   = 1'b0;
        SrcAddr = 8'h00;
        DstAddr = 8'h00;
        Length  = 9'h000;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checkOutput("resetBusy", 32'(Busy), 0);
        checkOutput("resetDone", 32'(Done), 0);
        checkOutput("resetWriteEn", 32'(memIf.MemWriteEn), 0);
        checkOutput("resetAddress", 32'(memIf.MemAddress), 0);
        checkOutput("resetWrData", 32'(memIf.MemWrData), 0);
        monitorOn = 1'b1;

        for (int i = 0; i < 256; i++) pokeMem(i, int'($urandom_range(0, 255)));

        // Basic four-byte copy.
        pokeMem(8'h10, 8'h11);
        pokeMem(8'h11, 8'h22);
        pokeMem(8'h12, 8'h33);
        pokeMem(8'h13, 8'h44);
        applyStimulus(8'h10, 8'h80, 4, 0);
        checkOutput("copy80", 32'(mem[8'h80]), 32'h11);
        checkOutput("copy81", 32'(mem[8'h81]), 32'h22);
        checkOutput("copy82", 32'(mem[8'h82]), 32'h33);
        checkOutput("copy83", 32'(mem[8'h83]), 32'h44);

        // Zero-length request and address wrap-around.
        applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0, 0);
        applyStimulus(8'hFE, 8'h01, 3, 0);

        // Overlap one ahead replicates the first source byte.
        pokeMem(8'h20, 8'hAA);
        applyStimulus(8'h20, 8'h21, 4, 0);
        for (int i = 0; i < 5; i++) checkOutput("fillAA", 32'(mem[8'h20 + i]), 32'hAA);

        // Reset during the third read: two bytes land, no Done.
        modelCopy(8'h30, 8'h90, 2, 3);
        @(negedge Clk);
        Start   = 1'b1;
        SrcAddr = 8'h30;
        DstAddr = 8'h90;
        Length  = 9'd4;
        t = cycle;
        startDone = doneCount;
        @(negedge Clk);
        Start = 1'b0;
        while (cycle < t + 5) @(negedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk);
        #1 Reset = 1'b0;
        checkOutput("abortBusy", 32'(Busy), 0);
        checkOutput("abortDone", 32'(Done), 0);
        repeat (6) @(negedge Clk);
        checkOutput("abortNoDone", doneCount - startDone, 0);
        checkOutput("abortDrained", readQ.size() + writeQ.size(), 0);

        // Start pulses mid-copy and in the DONE cycle are ignored.
        applyStimulus(8'h40, 8'h60, 2, 2);
        applyStimulus(8'h50, 8'h70, 3, 7);

        // Randomized copies plus one full-memory copy.
        repeat (20) applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 12)), 0);
        applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 256, 0);

        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== refMem[i]) diffs++;
        checkOutput("memImage", diffs, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_copier.md
MEM_COPIER -- requirements
Module: mem_copier

Interface
REQ-001 SHALL have parameter W, default 8, memory data width in bits.
REQ-002 SHALL have parameter A, default 8, memory address width; memory depth is 2**A.
REQ-003 SHALL have port Clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  copy request, sampled only in IDLE.
REQ-006 SHALL have port SrcAddr  input  A  first source address.
REQ-007 SHALL have port DstAddr  input  A  first destination address.
REQ-008 SHALL have port Length  input  A+1  byte count, 0..2**A.
REQ-009 SHALL have port Busy  output  1  high in READ and WRITE states.
REQ-010 SHALL have port Done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port MemAddress  output  A  single shared read/write address to the data memory.
REQ-012 SHALL have port MemWriteEn  output  1  memory write enable.
REQ-013 SHALL have port MemWrData  output  W  memory write data.
REQ-014 SHALL have port MemRdData  input  W  memory read data, combinational from MemAddress in the same cycle.

Function
REQ-015 SHALL implement states IDLE, READ, WRITE, DONE; memory is read or written, never both, in any cycle.
REQ-016 In IDLE with Start=1 at an edge, SHALL latch SrcAddr, DstAddr, Length, clear byte counter cnt, and go to READ if Length!=0, else DONE.
REQ-017 In IDLE with Start=0, SHALL stay in IDLE; SrcAddr/DstAddr/Length changes SHALL have no effect.
REQ-018 In READ, SHALL drive MemAddress=(src+cnt) mod 2**A, MemWriteEn=0, and at the edge capture MemRdData into a W-bit hold register, then go to WRITE.
REQ-019 In WRITE, SHALL drive MemAddress=(dst+cnt) mod 2**A, MemWriteEn=1, MemWrData=hold; at the edge increment cnt and go to DONE if cnt+1==len, else READ.
REQ-020 In DONE, SHALL assert Done=1 for exactly one cycle, then go to IDLE.
REQ-021 SHALL take 2*N+2 cycles per copy of N>=1 bytes: Start edge t, READ at t+1, Done high during cycle t+2N+1; Length=0 gives Done during cycle t+1 with no memory access.
REQ-022 Address arithmetic SHALL wrap modulo 2**A; cnt SHALL be A+1 bits so Length=2**A copies every location exactly once.
REQ-023 Start while not in IDLE (including DONE) SHALL be ignored; latched parameters SHALL not change mid-copy.
REQ-024 Overlapping regions SHALL be copied strictly ascending, one byte read then written at a time (dst=src+1 replicates byte src across the region).
REQ-025 MemAddress SHALL be 0, MemWriteEn 0 and MemWrData 0 in IDLE and DONE.
REQ-026 Busy SHALL be 0 in IDLE and DONE; Done SHALL be 0 outside DONE.

Reset
REQ-027 Reset=1 at an edge SHALL force IDLE, cnt=0, hold=0, latched parameters 0, taking priority over Start.
REQ-028 After reset, Busy, Done, MemWriteEn, MemAddress, MemWrData SHALL all be 0.
REQ-029 Reset mid-copy SHALL abort with no further write; bytes already written SHALL remain; no Done pulse.

Verification
REQ-030 Bench SHALL cover: mem[0x10..0x13]=11,22,33,44; Start Src=0x10 Dst=0x80 Len=4 -> mem[0x80..0x83]=11,22,33,44, Busy 8 cycles, Done during cycle t+9.
REQ-031 Bench SHALL cover: Len=0 -> Done during cycle t+1, MemWriteEn never 1, Busy never 1.
REQ-032 Bench SHALL cover: Src=0xFE Dst=0x01 Len=3 -> reads 0xFE,0xFF,0x00 in order, writes 0x01,0x02,0x03.
REQ-033 Bench SHALL cover: mem[0x20]=0xAA, Src=0x20 Dst=0x21 Len=4 -> mem[0x20..0x24] all 0xAA.
REQ-034 Bench SHALL cover: Len=4 copy, Reset asserted at the edge after the 2nd write -> exactly 2 destination bytes changed, IDLE next cycle, no Done.
REQ-035 Bench SHALL cover: Start pulsed again with new parameters during a Len=2 copy -> ignored, original copy completes unchanged, one Done.
